sdes_seq_ctrl: RTL
==================

// Module: sdes_seq_ctrl
// PURPOSE
//  Sequencing controller for the iterative S-DES datapath: accepts one 8-bit block plus 10-bit key over
//  valid/ready, runs key schedule, IP, two Feistel rounds (shared round function), swap and IP^-1 across
//  successive cycles, and returns the 8-bit result over valid/ready. Supports encrypt and decrypt
//  (subkey order reversed). Sits between the host block interface and the combinational round datapath.
// PARAMETERS
//  CNT_W     16  width of completed-block counter blk_cnt (saturating)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   block/key/mode/S-box tables valid
//  in_ready   out  1   controller can accept a block
//  in_data    in   8   plaintext (encrypt) or ciphertext (decrypt)
//  in_key     in   10  S-DES key
//  in_decrypt in   1   1=decrypt (K2 then K1), 0=encrypt (K1 then K2)
//  S0, S1     in   32  S-box tables; entry e=row*4+col at bits [2e+1:2e]
//  out_valid  out  1   result valid, held until out_ready
//  out_ready  in   1   consumer accepts result
//  out_data   out  8   result block
//  busy       out  1   state != IDLE
//  blk_cnt    out  CNT_W  number of results handed off (out_valid&&out_ready)
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset rst_n asynchronous, active-low. Reset: state=IDLE, in_ready=1,
//    out_valid=0, out_data=0, busy=0, blk_cnt=0, all internal regs 0. Reset mid-block discards it silently.
//  - Bit numbering: permutation tables 1-indexed from MSB. P10=3 5 2 7 4 10 1 9 8 6; P8=6 3 7 4 8 5 10 9;
//    IP=2 6 3 1 4 8 5 7; IP^-1=4 1 3 5 7 2 8 6; EP=4 1 2 3 2 3 4 1; P4=2 4 3 1. K1=P8(LS1(P10(key)))
//    per 5-bit half; K2=P8(LS3 of same halves). S-box input b1..b4: row={b1,b4}, col={b2,b3}.
//  - FSM: IDLE -> R1 -> R2 -> DONE -> IDLE.
//    IDLE: in_ready=1. On in_valid: latch L,R=IP(in_data), ka/kb=(K1,K2) or (K2,K1) if in_decrypt,
//          latch S0/S1 (tables need not stay stable afterwards); go R1.
//    R1:   {L,R} <= {R, L^F(R,ka)} (round + swap); go R2. in_ready=0.
//    R2:   out_data <= IP^-1({L^F(R,kb), R}); out_valid<=1; go DONE.
//    DONE: hold out_valid/out_data stable until out_ready; on handshake out_valid<=0, blk_cnt++, go IDLE.
//  - Latency: out_valid rises 2 clocks after the accepting edge; min 4 cycles/block with out_ready=1.
//  - in_valid in R1/R2/DONE is ignored (in_ready=0); host must hold it. Data inputs sampled only at accept.
//  - out_ready while out_valid=0 has no effect. blk_cnt saturates at all-ones, never wraps.
//  - F(R,k)=P4(S0(EP(R)^k)[7:4] || S1(EP(R)^k)[3:0]).
// STRUCTURE
//  - Package sdes_pkg: state encoding (IDLE=0,R1=1,R2=2,DONE=3), permutation functions p10/p8/ip/
//    ip_inv/ep/p4, sbox_lookup(table,nibble), keygen function returning {K1,K2}.
//  - One sub-module: sdes_fk (combinational round function: EP, key XOR, two S-box lookups, P4, XOR
//    into left half); instantiated once, key select muxed by state (ka in R1, kb in R2).
//  - Controller holds FSM, L/R regs, ka/kb, latched S-box tables, output reg, counter.
// TESTING (S0=32'hB7D81BB1, S1=32'hC613D2E4 = standard tables)
//  1 Encrypt key=10'b1010000010, in=8'b10010111, out_ready=1 -> out_data=8'b00111000 2 clks after
//    accept; blk_cnt=1; busy high 3 cycles.
//  2 Decrypt same key, in=8'b00111000 -> out_data=8'b10010111.
//  3 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid/out_data stable, in_ready=0,
//    new in_valid ignored; out_ready=1 -> handoff, IDLE, next block accepted.
//  4 Change S0/S1/in_key/in_data during R1/R2 -> result identical to test 1 (accept-time sampling).
//  5 Assert rst_n low asynchronously in R2 -> out_valid=0, in_ready=1, blk_cnt=0 immediately;
//    next block after release processes correctly.
//  6 Random key/block, 1000 encrypt-then-decrypt round trips vs reference model -> plaintext recovered;
//    blk_cnt=2000 (CNT_W=16); CNT_W=2 run saturates at 3.

Source files
------------

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: controller state encoding, bit permutations,
// S-box lookup and key schedule used by the sequencing controller.
package sdes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_R1   = 2'd1,
        ST_R2   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Table position p (1-indexed from the MSB) of an n-bit word is bit [n-p].
    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] x);
        return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] x);
        return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    // Row comes from the outer bits, column from the inner bits of the nibble.
    function automatic logic [1:0] sbox_lookup(input logic [31:0] tbl, input logic [3:0] n);
        logic [3:0] entry;
        entry = {n[3], n[0], n[2], n[1]};
        return tbl[{entry, 1'b0} +: 2];
    endfunction

    function automatic logic [4:0] rotl5(input logic [4:0] h, input int unsigned n);
        logic [4:0] o;
        o = h;
        for (int i = 0; i < 3; i++) begin
            if (i < n) o = {o[3:0], o[4]};
        end
        return o;
    endfunction

    // Returns {K1, K2}; K2 uses the P10 halves rotated by three in total.
    function automatic logic [15:0] keygen(input logic [9:0] key);
        logic [9:0] p;
        logic [7:0] k1;
        logic [7:0] k2;
        p  = p10(key);
        k1 = p8({rotl5(p[9:5], 1), rotl5(p[4:0], 1)});
        k2 = p8({rotl5(p[9:5], 3), rotl5(p[4:0], 3)});
        return {k1, k2};
    endfunction

endpackage

// File: rtl/sdes_seq_ctrl_if.sv
// Host-side block interface of the S-DES controller: input block/key/tables
// handshake and result handshake.
interface sdes_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [9:0]  in_key;
    logic        in_decrypt;
    logic [31:0] S0;
    logic [31:0] S1;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    modport master (
        output in_valid, in_data, in_key, in_decrypt, S0, S1, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, S0, S1, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sdes_fk.sv
// Combinational S-DES round function: expands the right half, mixes in the
// subkey, substitutes through both S-boxes and folds the result into the left half.
module sdes_fk
    import sdes_pkg::*;
(
    input  logic [3:0]  l,
    input  logic [3:0]  r,
    input  logic [7:0]  k,
    input  logic [31:0] s0,
    input  logic [31:0] s1,
    output logic [3:0]  l_out
);

    logic [7:0] mixed;
    logic [1:0] s0_val;
    logic [1:0] s1_val;

    assign mixed  = ep(r) ^ k;
    assign s0_val = sbox_lookup(s0, mixed[7:4]);
    assign s1_val = sbox_lookup(s1, mixed[3:0]);
    assign l_out  = l ^ p4({s0_val, s1_val});

endmodule

// File: rtl/sdes_seq_ctrl.sv
// Iterative S-DES sequencing controller: one block per pass through
// IDLE -> R1 -> R2 -> DONE, sharing a single round-function instance.
module sdes_seq_ctrl
    import sdes_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    sdes_seq_ctrl_if.slave   bus,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  l_q;
    logic [3:0]  r_q;
    logic [7:0]  ka_q;
    logic [7:0]  kb_q;
    logic [31:0] s0_q;
    logic [31:0] s1_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        in_ready_c;
    logic        accept;
    logic        handoff;
    logic [7:0]  fk_key;
    logic [3:0]  fk_l;
    logic [15:0] subkeys;
    logic [7:0]  ip_data;

    assign subkeys       = keygen(bus.in_key);
    assign ip_data       = ip(bus.in_data);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        handoff    = 1'b0;
        fk_key     = ka_q;
        case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                busy       = 1'b0;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_R1;
                end
            end
            ST_R1: state_nxt = ST_R2;
            ST_R2: begin
                fk_key    = kb_q;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    handoff   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    sdes_fk u_fk (
        .l     (l_q),
        .r     (r_q),
        .k     (fk_key),
        .s0    (s0_q),
        .s1    (s1_q),
        .l_out (fk_l)
    );

    // Everything the block needs is captured at accept so the host may move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q         <= '0;
            r_q         <= '0;
            ka_q        <= '0;
            kb_q        <= '0;
            s0_q        <= '0;
            s1_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        {l_q, r_q} <= ip_data;
                        s0_q       <= bus.S0;
                        s1_q       <= bus.S1;
                        if (bus.in_decrypt) begin
                            ka_q <= subkeys[7:0];
                            kb_q <= subkeys[15:8];
                        end else begin
                            ka_q <= subkeys[15:8];
                            kb_q <= subkeys[7:0];
                        end
                    end
                end
                ST_R1: begin
                    l_q <= r_q;
                    r_q <= fk_l;
                end
                ST_R2: begin
                    out_data_q  <= ip_inv({fk_l, r_q});
                    out_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (handoff) begin
                        out_valid_q <= 1'b0;
                        if (blk_cnt != {CNT_W{1'b1}}) blk_cnt <= blk_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
